writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have: CLK  input  1  clock, all state updates on rising edge.
REQ-002 SHALL have: RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: PIPE_WE  input  1  main-pipeline writeback valid.
REQ-004 SHALL have: PIPE_RD  input  5  main-pipeline destination register.
REQ-005 SHALL have: PIPE_DATA  input  32  main-pipeline writeback data.
REQ-006 SHALL have: LL_VALID  input  1  long-latency unit (mul/div/load) result valid.
REQ-007 SHALL have: LL_RD  input  5  long-latency destination register.
REQ-008 SHALL have: LL_DATA  input  32  long-latency result data.
REQ-009 SHALL have: LL_READY  output  1  arbiter can accept a long-latency result.
REQ-010 SHALL have: ISSUE_VALID  input  1  long-latency op issued this cycle.
REQ-011 SHALL have: ISSUE_RD  input  5  destination of the issued long-latency op.
REQ-012 SHALL have: BUSY  output  32  per-register pending-write scoreboard; bit 0 always 0.
REQ-013 SHALL have: RF_WE, RF_WADDR, RF_WDATA  outputs  1/5/32  register-file write port.
REQ-014 SHALL have: FIFO_COUNT  output  2  long-latency buffer occupancy, 0..2.

Function
REQ-015 SHALL buffer long-latency results in a 2-entry FIFO; LL_READY = (FIFO_COUNT < 2), derived from registered state only.
REQ-016 SHALL accept an LL result at a rising edge when LL_VALID and LL_READY are both 1; LL_RD = 0 is accepted and discarded (not enqueued).
REQ-017 SHALL not accept a push when full, even if a pop occurs in the same cycle.
REQ-018 SHALL register RF_WE/RF_WADDR/RF_WDATA: outputs in cycle N+1 reflect the arbitration decision of cycle N.
REQ-019 SHALL give the pipeline strict priority: if PIPE_WE = 1 and PIPE_RD != 0, load the pipeline write to the RF outputs; no FIFO pop.
REQ-020 SHALL otherwise, if the FIFO is non-empty, pop the head entry and load it to the RF outputs.
REQ-021 SHALL otherwise drive RF_WE = 0 next cycle; RF_WADDR/RF_WDATA are held.
REQ-022 SHALL ignore PIPE_WE with PIPE_RD = 0 (treated as idle); RF_WE is never asserted with RF_WADDR = 0.
REQ-023 SHALL not bypass: an entry pushed at edge k is eligible to pop at edge k+1 at the earliest, giving RF_WE at the earliest after edge k+1.
REQ-024 SHALL support push and pop in the same cycle when not full; FIFO_COUNT is unchanged and order is preserved (FIFO order).
REQ-025 SHALL set BUSY[ISSUE_RD] at the edge where ISSUE_VALID = 1 and ISSUE_RD != 0.
REQ-026 SHALL clear BUSY[r] at the edge where an LL entry with rd = r is popped to the RF outputs.
REQ-027 SHALL let set win over clear when both target the same register at the same edge.
REQ-028 SHALL not alter BUSY on pipeline writes.

Reset
REQ-029 SHALL, on RST = 1 at a rising edge, clear FIFO contents and pointers, FIFO_COUNT = 0, BUSY = 0, RF_WE = 0, RF_WADDR = 0, RF_WDATA = 0.
REQ-030 SHALL, on reset mid-operation, discard buffered LL results without writing them; LL_READY = 1 from the first cycle after reset.
REQ-031 SHALL give RST priority over all simultaneous push, pop, issue and pipeline events.

Verification
REQ-032 SHALL pass: LL_VALID with LL_RD = 5, LL_DATA = 0x1234, pipe idle -> FIFO_COUNT = 1, then next cycle RF_WE = 1, RF_WADDR = 5, RF_WDATA = 0x1234, FIFO_COUNT = 0.
REQ-033 SHALL pass: PIPE_WE held with PIPE_RD = 3 while LL pushes rd 7 then rd 8 -> FIFO_COUNT = 2, LL_READY = 0; a third LL_VALID is not accepted; after PIPE_WE drops, writes to x7 then x8 in consecutive cycles.
REQ-034 SHALL pass: ISSUE_VALID with ISSUE_RD = 10 -> BUSY[10] = 1; LL result rd 10 popped -> BUSY[10] = 0 the same edge RF_WE asserts; issue rd 10 coinciding with that pop -> BUSY[10] stays 1.
REQ-035 SHALL pass: PIPE_WE = 1 with PIPE_RD = 0, and LL_RD = 0 pushes -> RF_WE stays 0, FIFO_COUNT stays 0, BUSY[0] = 0.
REQ-036 SHALL pass: FIFO holding 2 entries and BUSY = 0x0000_0300, RST asserted -> next cycle FIFO_COUNT = 0, BUSY = 0, RF_WE = 0, LL_READY = 1; no write of buffered data afterwards.
REQ-037 SHALL pass: FIFO_COUNT = 1, simultaneous accepted push and pop with pipe idle -> FIFO_COUNT stays 1, older entry written first.

Source files
------------

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - register-file writeback arbiter with 2-deep long-latency FIFO and busy scoreboard
module writeback_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PIPE_WE,
  input  logic [4:0]  PIPE_RD,
  input  logic [31:0] PIPE_DATA,
  input  logic        LL_VALID,
  input  logic [4:0]  LL_RD,
  input  logic [31:0] LL_DATA,
  output logic        LL_READY,
  input  logic        ISSUE_VALID,
  input  logic [4:0]  ISSUE_RD,
  output logic [31:0] BUSY,
  output logic        RF_WE,
  output logic [4:0]  RF_WADDR,
  output logic [31:0] RF_WDATA,
  output logic [1:0]  FIFO_COUNT
);

  logic [4:0]  fifo_rd_q   [2];
  logic [31:0] fifo_data_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [31:0] busy_q, busy_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic pipe_win, push, pop;

  assign LL_READY   = (count_q != 2'd2);
  assign pipe_win   = PIPE_WE && (PIPE_RD != 5'd0);
  // rd = 0 results are acknowledged but dropped, so they never reach the FIFO
  assign push       = LL_VALID && LL_READY && (LL_RD != 5'd0);
  assign pop        = !pipe_win && (count_q != 2'd0);

  always_comb begin
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (pipe_win) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = PIPE_RD;
      rf_wdata_d = PIPE_DATA;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
      busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
    end

    // Applied after the clear so a same-edge issue keeps the register pending
    if (ISSUE_VALID && (ISSUE_RD != 5'd0)) begin
      busy_d[ISSUE_RD] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fifo_rd_q[0]   <= 5'd0;
      fifo_rd_q[1]   <= 5'd0;
      fifo_data_q[0] <= 32'd0;
      fifo_data_q[1] <= 32'd0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      busy_q         <= 32'd0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 5'd0;
      rf_wdata_q     <= 32'd0;
    end else begin
      if (push) begin
        fifo_rd_q[wr_ptr_q]   <= LL_RD;
        fifo_data_q[wr_ptr_q] <= LL_DATA;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      busy_q     <= busy_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign BUSY       = busy_q;
  assign RF_WE      = rf_we_q;
  assign RF_WADDR   = rf_waddr_q;
  assign RF_WDATA   = rf_wdata_q;
  assign FIFO_COUNT = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PIPE_WE;
  logic [4:0]  PIPE_RD;
  logic [31:0] PIPE_DATA;
  logic        LL_VALID;
  logic [4:0]  LL_RD;
  logic [31:0] LL_DATA;
  logic        LL_READY;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_RD;
  logic [31:0] BUSY;
  logic        RF_WE;
  logic [4:0]  RF_WADDR;
  logic [31:0] RF_WDATA;
  logic [1:0]  FIFO_COUNT;

  int checks = 0;
  int errors = 0;

  writeback_arbiter dut (
    .CLK(CLK), .RST(RST),
    .PIPE_WE(PIPE_WE), .PIPE_RD(PIPE_RD), .PIPE_DATA(PIPE_DATA),
    .LL_VALID(LL_VALID), .LL_RD(LL_RD), .LL_DATA(LL_DATA), .LL_READY(LL_READY),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .BUSY(BUSY),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA), .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    PIPE_WE = 0; PIPE_RD = 0; PIPE_DATA = 0;
    LL_VALID = 0; LL_RD = 0; LL_DATA = 0;
    ISSUE_VALID = 0; ISSUE_RD = 0;
  endtask

  task automatic test_reset();
    RST = 1; idle_inputs();
    step(); step();
    RST = 0;
    checks++; if (FIFO_COUNT !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", FIFO_COUNT); end
    checks++; if (BUSY !== 32'd0) begin errors++; $display("FAIL reset_busy got %h exp 0", BUSY); end
    checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", RF_WE); end
    checks++; if (RF_WADDR !== 5'd0 || RF_WDATA !== 32'd0) begin errors++; $display("FAIL reset_waddr_wdata got %0d/%h exp 0/0", RF_WADDR, RF_WDATA); end
    checks++; if (LL_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", LL_READY); end
  endtask

  task automatic test_single_ll();
    LL_VALID = 1; LL_RD = 5; LL_DATA = 32'h1234;
    step();
    LL_VALID = 0;
    checks++; if (FIFO_COUNT !== 2'd1 || RF_WE !== 1'b0) begin errors++; $display("FAIL single_push got count=%0d we=%b exp 1/0", FIFO_COUNT, RF_WE); end
    step();
    checks++; if (RF_WE !== 1'b1 || RF_WADDR !== 5'd5 || RF_WDATA !== 32'h1234 || FIFO_COUNT !== 2'd0) begin
      errors++; $display("FAIL single_write got we=%b addr=%0d data=%h count=%0d exp 1/5/1234/0", RF_WE, RF_WADDR, RF_WDATA, FIFO_COUNT); end
    step();
    checks++; if (RF_WE !== 1'b0 || RF_WADDR !== 5'd5 || RF_WDATA !== 32'h1234) begin
      errors++; $display("FAIL single_hold got we=%b addr=%0d data=%h exp 0/5/1234", RF_WE, RF_WADDR, RF_WDATA); end
  endtask

  task automatic test_pipe_priority();
    PIPE_WE = 1; PIPE_RD = 3; PIPE_DATA = 32'hAAAA;
    LL_VALID = 1; LL_RD = 7; LL_DATA = 32'h7777;
    step();
    checks++; if (RF_WE !== 1'b1 || RF_WADDR !== 5'd3 || RF_WDATA !== 32'hAAAA || FIFO_COUNT !== 2'd1) begin
      errors++; $display("FAIL prio_pipe1 got we=%b addr=%0d data=%h count=%0d exp 1/3/aaaa/1", RF_WE, RF_WADDR, RF_WDATA, FIFO_COUNT); end
    LL_RD = 8; LL_DATA = 32'h8888;
    step();
    checks++; if (FIFO_COUNT !== 2'd2 || LL_READY !== 1'b0) begin errors++; $display("FAIL prio_full got count=%0d ready=%b exp 2/0", FIFO_COUNT, LL_READY); end
    LL_RD = 9; LL_DATA = 32'h9999;
    step();
    checks++; if (FIFO_COUNT !== 2'd2 || RF_WADDR !== 5'd3) begin errors++; $display("FAIL prio_reject got count=%0d addr=%0d exp 2/3", FIFO_COUNT, RF_WADDR); end
    idle_inputs();
    step();
    checks++; if (RF_WE !== 1'b1 || RF_WADDR !== 5'd7 || RF_WDATA !== 32'h7777 || FIFO_COUNT !== 2'd1) begin
      errors++; $display("FAIL prio_drain7 got we=%b addr=%0d data=%h count=%0d exp 1/7/7777/1", RF_WE, RF_WADDR, RF_WDATA, FIFO_COUNT); end
    step();
    checks++; if (RF_WE !== 1'b1 || RF_WADDR !== 5'd8 || RF_WDATA !== 32'h8888 || FIFO_COUNT !== 2'd0) begin
      errors++; $display("FAIL prio_drain8 got we=%b addr=%0d data=%h count=%0d exp 1/8/8888/0", RF_WE, RF_WADDR, RF_WDATA, FIFO_COUNT); end
    step();
    checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL prio_no9 got we=%b addr=%0d exp we 0", RF_WE, RF_WADDR); end
  endtask

  task automatic test_busy();
    ISSUE_VALID = 1; ISSUE_RD = 10;
    step();
    ISSUE_VALID = 0;
    checks++; if (BUSY !== 32'h0000_0400) begin errors++; $display("FAIL busy_set got %h exp 00000400", BUSY); end
    LL_VALID = 1; LL_RD = 10; LL_DATA = 32'hA0;
    step();
    LL_VALID = 0;
    checks++; if (BUSY !== 32'h0000_0400 || FIFO_COUNT !== 2'd1) begin errors++; $display("FAIL busy_held got busy=%h count=%0d exp 00000400/1", BUSY, FIFO_COUNT); end
    step();
    checks++; if (RF_WE !== 1'b1 || RF_WADDR !== 5'd10 || BUSY !== 32'd0) begin
      errors++; $display("FAIL busy_clear got we=%b addr=%0d busy=%h exp 1/10/0", RF_WE, RF_WADDR, BUSY); end
    ISSUE_VALID = 1; ISSUE_RD = 10; LL_VALID = 1; LL_RD = 10; LL_DATA = 32'hA1;
    step();
    LL_VALID = 0;
    step();
    ISSUE_VALID = 0;
    checks++; if (RF_WE !== 1'b1 || RF_WADDR !== 5'd10 || RF_WDATA !== 32'hA1 || BUSY !== 32'h0000_0400) begin
      errors++; $display("FAIL busy_set_wins got we=%b addr=%0d data=%h busy=%h exp 1/10/a1/00000400", RF_WE, RF_WADDR, RF_WDATA, BUSY); end
    LL_VALID = 1; LL_RD = 10; LL_DATA = 32'hA2;
    step();
    LL_VALID = 0;
    step();
    checks++; if (BUSY !== 32'd0 || RF_WDATA !== 32'hA2) begin errors++; $display("FAIL busy_final got busy=%h data=%h exp 0/a2", BUSY, RF_WDATA); end
    PIPE_WE = 1; PIPE_RD = 12; PIPE_DATA = 32'hC;
    step();
    PIPE_WE = 0;
    checks++; if (BUSY !== 32'd0 || RF_WADDR !== 5'd12) begin errors++; $display("FAIL busy_pipe got busy=%h addr=%0d exp 0/12", BUSY, RF_WADDR); end
  endtask

  task automatic test_rd_zero();
    PIPE_WE = 1; PIPE_RD = 0; PIPE_DATA = 32'hDEAD;
    LL_VALID = 1; LL_RD = 0; LL_DATA = 32'hBEEF;
    ISSUE_VALID = 1; ISSUE_RD = 0;
    step();
    step();
    idle_inputs();
    checks++; if (RF_WE !== 1'b0 || FIFO_COUNT !== 2'd0) begin errors++; $display("FAIL zero_we_count got we=%b count=%0d exp 0/0", RF_WE, FIFO_COUNT); end
    checks++; if (BUSY !== 32'd0 || LL_READY !== 1'b1) begin errors++; $display("FAIL zero_busy got busy=%h ready=%b exp 0/1", BUSY, LL_READY); end
    step();
    checks++; if (RF_WE !== 1'b0 || RF_WADDR !== 5'd12) begin errors++; $display("FAIL zero_after got we=%b addr=%0d exp 0/12", RF_WE, RF_WADDR); end
  endtask

  task automatic test_reset_mid();
    PIPE_WE = 1; PIPE_RD = 1; PIPE_DATA = 32'h11;
    ISSUE_VALID = 1; ISSUE_RD = 8;
    LL_VALID = 1; LL_RD = 20; LL_DATA = 32'h2020;
    step();
    ISSUE_RD = 9; LL_RD = 21; LL_DATA = 32'h2121;
    step();
    checks++; if (FIFO_COUNT !== 2'd2 || BUSY !== 32'h0000_0300) begin errors++; $display("FAIL rstmid_pre got count=%0d busy=%h exp 2/00000300", FIFO_COUNT, BUSY); end
    RST = 1; PIPE_WE = 1; PIPE_RD = 4; ISSUE_RD = 15; LL_VALID = 0;
    step();
    RST = 0; idle_inputs();
    checks++; if (FIFO_COUNT !== 2'd0 || BUSY !== 32'd0 || RF_WE !== 1'b0 || LL_READY !== 1'b1) begin
      errors++; $display("FAIL rstmid_post got count=%0d busy=%h we=%b ready=%b exp 0/0/0/1", FIFO_COUNT, BUSY, RF_WE, LL_READY); end
    checks++; if (RF_WADDR !== 5'd0 || RF_WDATA !== 32'd0) begin errors++; $display("FAIL rstmid_addr got %0d/%h exp 0/0", RF_WADDR, RF_WDATA); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (RF_WE !== 1'b0 || FIFO_COUNT !== 2'd0) begin errors++; $display("FAIL rstmid_nowrite cycle %0d got we=%b addr=%0d exp we 0", i, RF_WE, RF_WADDR); end
    end
  endtask

  task automatic test_push_pop();
    PIPE_WE = 1; PIPE_RD = 2; PIPE_DATA = 32'h22;
    LL_VALID = 1; LL_RD = 11; LL_DATA = 32'hB0B0;
    step();
    checks++; if (FIFO_COUNT !== 2'd1) begin errors++; $display("FAIL pp_pre got count=%0d exp 1", FIFO_COUNT); end
    PIPE_WE = 0; LL_RD = 12; LL_DATA = 32'hC0C0;
    step();
    LL_VALID = 0;
    checks++; if (FIFO_COUNT !== 2'd1 || RF_WE !== 1'b1 || RF_WADDR !== 5'd11 || RF_WDATA !== 32'hB0B0) begin
      errors++; $display("FAIL pp_older got count=%0d we=%b addr=%0d data=%h exp 1/1/11/b0b0", FIFO_COUNT, RF_WE, RF_WADDR, RF_WDATA); end
    step();
    checks++; if (FIFO_COUNT !== 2'd0 || RF_WE !== 1'b1 || RF_WADDR !== 5'd12 || RF_WDATA !== 32'hC0C0) begin
      errors++; $display("FAIL pp_newer got count=%0d we=%b addr=%0d data=%h exp 0/1/12/c0c0", FIFO_COUNT, RF_WE, RF_WADDR, RF_WDATA); end
    step();
    checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL pp_idle got we=%b exp 0", RF_WE); end
  endtask

  initial begin
    test_reset();
    test_single_ll();
    test_pipe_priority();
    test_busy();
    test_rd_zero();
    test_reset_mid();
    test_push_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
